tmds_decoder: RTL



---
 rtl/tmds_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tmds_decoder.sv
// One TMDS receive channel: finds word alignment on control tokens, then decodes
// video symbols to bytes and control tokens to {C1,C0}, reporting lock status.
module tmds_decoder #(
  parameter int SEARCH_CYCLES = 16,
  parameter int LOCK_TOKENS   = 8,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] symbol_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TOK_W   = $clog2(LOCK_TOKENS + 1);
  localparam int DWELL_W = $clog2(SEARCH_CYCLES + 1);
  localparam int GAP_W   = $clog2(LOSS_TIMEOUT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state, state_n;
  logic [9:0]         sym_d;
  logic [19:0]        win_shift;
  logic [9:0]         aligned;
  logic               is_token;
  logic [1:0]         token_val;
  logic [7:0]         dp;
  logic [7:0]         video;
  logic [3:0]         offset_n;
  logic [TOK_W-1:0]   tok_cnt, tok_cnt_n;
  logic [DWELL_W-1:0] dwell, dwell_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [7:0]         data_n;
  logic [1:0]         ctrl_n;
  logic               de_n;

  always_ff @(posedge clk) begin
    sym_d <= symbol_in;
  end

  // Bit 0 of the window is the earliest bit on the wire, so shifting right slides the word boundary later.
  always_comb begin
    win_shift = {symbol_in, sym_d} >> offset;
    aligned   = win_shift[9:0];
    is_token  = 1'b1;
    token_val = 2'b00;
    case (aligned)
      10'h354: token_val = 2'b00;
      10'h0AB: token_val = 2'b01;
      10'h154: token_val = 2'b10;
      10'h2AB: token_val = 2'b11;
      default: is_token  = 1'b0;
    endcase
    dp    = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    video = {dp[7:1] ^ dp[6:0] ^ {7{~aligned[8]}}, dp[0]};
  end

  always_comb begin
    state_n   = state;
    offset_n  = offset;
    tok_cnt_n = tok_cnt;
    dwell_n   = dwell;
    gap_cnt_n = gap_cnt;
    case (state)
      HUNT: begin
        if (is_token) begin
          if (tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
            state_n   = LOCKED;
            gap_cnt_n = '0;
          end
          tok_cnt_n = tok_cnt + 1'b1;
        end else begin
          tok_cnt_n = '0;
          if (dwell == DWELL_W'(SEARCH_CYCLES - 1)) begin
            dwell_n  = '0;
            offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (is_token) begin
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
          if (gap_cnt == GAP_W'(LOSS_TIMEOUT - 1)) begin
            state_n   = HUNT;
            tok_cnt_n = '0;
            dwell_n   = '0;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Outputs follow the state being entered, so the locking and timeout edges already obey the new rules.
  always_comb begin
    data_n = 8'h00;
    ctrl_n = 2'b00;
    de_n   = 1'b0;
    if (state_n == LOCKED) begin
      if (is_token) begin
        ctrl_n = token_val;
      end else begin
        ctrl_n = ctrl_out;
        de_n   = 1'b1;
        data_n = video;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      offset   <= 4'd0;
      tok_cnt  <= '0;
      dwell    <= '0;
      gap_cnt  <= '0;
      data_out <= 8'h00;
      ctrl_out <= 2'b00;
      de_out   <= 1'b0;
    end else begin
      state    <= state_n;
      offset   <= offset_n;
      tok_cnt  <= tok_cnt_n;
      dwell    <= dwell_n;
      gap_cnt  <= gap_cnt_n;
      data_out <= data_n;
      ctrl_out <= ctrl_n;
      de_out   <= de_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
